// File: rtl/dpb_arb_pkg.sv
// Shared defaults and the round-robin pick function for the DPB port arbiter.
package dpb_arb_pkg;
  localparam int DEF_AW       = 10;
  localparam int DEF_DW       = 8;
  localparam int DEF_LOCK_MAX = 16;
  localparam int MAX_NREQ     = 4;

  // One-hot winner: first valid requester in cyclic order after `last`.
  function automatic logic [MAX_NREQ-1:0] rr_pick(input logic [MAX_NREQ-1:0] valid,
                                                  input logic [1:0] last,
                                                  input int n);
    logic [MAX_NREQ-1:0] g;
    logic [1:0] idx;
    logic found;
    g = '0;
    found = 1'b0;
    for (int k = 1; k <= MAX_NREQ; k++) begin
      if (k <= n) begin
        idx = 2'((int'(last) + k) % n);
        if (!found && valid[idx]) begin
          g[idx] = 1'b1;
          found = 1'b1;
        end
      end
    end
    return g;
  endfunction
endpackage

// File: rtl/dpb_rr_pick.sv
// Combinational round-robin priority picker over NREQ requesters.
module dpb_rr_pick
  import dpb_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int LW   = (NREQ > 2) ? 2 : 1
) (
  input  logic [NREQ-1:0] valid,
  input  logic [LW-1:0]   last,
  output logic [NREQ-1:0] gnt
);
  logic [MAX_NREQ-1:0] pick;
  logic                unused_hi;

  assign pick      = rr_pick(MAX_NREQ'(valid), 2'(last), NREQ);
  assign gnt       = pick[NREQ-1:0];
  assign unused_hi = ^pick;
endmodule

// File: rtl/dpb_port_arbiter.sv
// Round-robin arbiter with bounded burst lock sharing one Gowin DPB port;
// read data comes back one cycle after grant, tagged one-hot to the issuer.
module dpb_port_arbiter
  import dpb_arb_pkg::*;
#(
  parameter int NREQ     = 2,
  parameter int AW       = DEF_AW,
  parameter int DW       = DEF_DW,
  parameter int LOCK_MAX = DEF_LOCK_MAX
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ-1:0]   req_we,
  input  logic [NREQ-1:0]   req_lock,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]   req_gnt,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [DW-1:0]     rsp_data,
  output logic              ram_ce,
  output logic              ram_oce,
  output logic              ram_reset,
  output logic              ram_we,
  output logic [AW-1:0]     ram_ad,
  output logic [DW-1:0]     ram_din,
  input  logic [DW-1:0]     ram_dout
);
  localparam int LW = (NREQ > 2) ? 2 : 1;

  logic [LW-1:0]   last_gnt, w;
  logic [7:0]      lock_cnt;
  logic            lock_q;
  logic [NREQ-1:0] rr_gnt, last_oh, gnt, pend_rd;
  logic [AW-1:0]   ad_q;
  logic [DW-1:0]   din_q;
  logic            lock_act, any_gnt;

  dpb_rr_pick #(.NREQ(NREQ), .LW(LW)) u_pick (
    .valid(req_valid),
    .last (last_gnt),
    .gnt  (rr_gnt)
  );

  assign last_oh = NREQ'(1) << last_gnt;

  // lock_cnt is nonzero only if the previous cycle granted, so it also
  // qualifies lock_q as belonging to the immediately preceding grant.
  always_comb begin
    lock_act = lock_q && (lock_cnt != 8'd0) && (|(req_valid & last_oh))
               && (int'(lock_cnt) < LOCK_MAX);
    gnt = '0;
    if (!reset) gnt = lock_act ? last_oh : rr_gnt;
    any_gnt = |gnt;
    w = '0;
    for (int i = 0; i < NREQ; i++)
      if (gnt[i]) w = LW'(i);
  end

  assign req_gnt   = gnt;
  assign ram_ce    = any_gnt;
  assign ram_we    = any_gnt & req_we[w];
  assign ram_ad    = any_gnt ? req_addr[int'(w)*AW +: AW] : ad_q;
  assign ram_din   = any_gnt ? req_wdata[int'(w)*DW +: DW] : din_q;
  assign ram_oce   = 1'b1;
  assign ram_reset = reset;
  assign rsp_valid = pend_rd;
  assign rsp_data  = ram_dout;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_gnt <= LW'(NREQ-1);
      lock_cnt <= 8'd0;
      lock_q   <= 1'b0;
      pend_rd  <= '0;
      ad_q     <= '0;
      din_q    <= '0;
    end else if (any_gnt) begin
      last_gnt <= w;
      lock_cnt <= lock_act ? lock_cnt + 8'd1 : 8'd1;
      lock_q   <= req_lock[w];
      pend_rd  <= req_we[w] ? '0 : gnt;
      ad_q     <= ram_ad;
      din_q    <= ram_din;
    end else begin
      lock_cnt <= 8'd0;
      lock_q   <= 1'b0;
      pend_rd  <= '0;
    end
  end
endmodule

// File: tb/tb_dpb_port_arbiter.sv
// Directed bench for dpb_port_arbiter with a behavioural 1024x8 bypass-read RAM.
module tb_dpb_port_arbiter;
  localparam int NREQ = 2;
  localparam int AW   = 10;
  localparam int DW   = 8;

  logic clk = 1'b0;
  logic reset;
  logic [NREQ-1:0]    req_valid, req_we, req_lock, req_gnt, rsp_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [DW-1:0]      rsp_data, ram_din, ram_dout;
  logic               ram_ce, ram_oce, ram_reset, ram_we;
  logic [AW-1:0]      ram_ad;
  logic [DW-1:0]      mem [0:1023];
  int checks = 0;
  int errors = 0;

  dpb_port_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .LOCK_MAX(16)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_we(req_we), .req_lock(req_lock),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_gnt(req_gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .ram_ce(ram_ce), .ram_oce(ram_oce), .ram_reset(ram_reset), .ram_we(ram_we),
    .ram_ad(ram_ad), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (ram_ce) begin
      if (ram_we) mem[ram_ad] <= ram_din;
      else        ram_dout <= mem[ram_ad];
    end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic v, input logic we, input logic lk,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i] = v;
    req_we[i]    = we;
    req_lock[i]  = lk;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic idle_all();
    req_valid = '0;
    req_we    = '0;
    req_lock  = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_all();
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_addr = '0;
    req_wdata = '0;
    idle_all();
    req_valid = 2'b11;
    step();
    mid();
    checks++; if (req_gnt !== 2'b00) begin errors++; $display("FAIL rst_gnt got %b exp 00", req_gnt); end
    checks++; if (ram_ce !== 1'b0) begin errors++; $display("FAIL rst_ce got %b exp 0", ram_ce); end
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL rst_we got %b exp 0", ram_we); end
    checks++; if (ram_reset !== 1'b1) begin errors++; $display("FAIL rst_ram_reset got %b exp 1", ram_reset); end
    checks++; if (ram_ad !== 10'h000) begin errors++; $display("FAIL rst_ad got %h exp 000", ram_ad); end
    checks++; if (ram_din !== 8'h00) begin errors++; $display("FAIL rst_din got %h exp 00", ram_din); end
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL rst_rsp got %b exp 00", rsp_valid); end
    checks++; if (ram_oce !== 1'b1) begin errors++; $display("FAIL rst_oce got %b exp 1", ram_oce); end
    step();
    reset = 1'b0;
    idle_all();
    mid();
    checks++; if (ram_reset !== 1'b0) begin errors++; $display("FAIL rel_ram_reset got %b exp 0", ram_reset); end
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL rel_rsp got %b exp 00", rsp_valid); end
    step();
  endtask

  task automatic test_write_read();
    set_req(0, 1'b1, 1'b1, 1'b0, 10'h012, 8'hA5);
    mid();
    checks++; if (req_gnt !== 2'b01) begin errors++; $display("FAIL wr_gnt got %b exp 01", req_gnt); end
    checks++; if (ram_ce !== 1'b1) begin errors++; $display("FAIL wr_ce got %b exp 1", ram_ce); end
    checks++; if (ram_we !== 1'b1) begin errors++; $display("FAIL wr_we got %b exp 1", ram_we); end
    checks++; if (ram_ad !== 10'h012) begin errors++; $display("FAIL wr_ad got %h exp 012", ram_ad); end
    checks++; if (ram_din !== 8'hA5) begin errors++; $display("FAIL wr_din got %h exp a5", ram_din); end
    step();
    set_req(0, 1'b1, 1'b0, 1'b0, 10'h012, 8'h00);
    mid();
    checks++; if (req_gnt !== 2'b01) begin errors++; $display("FAIL rd_gnt got %b exp 01", req_gnt); end
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL rd_we got %b exp 0", ram_we); end
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL wr_norsp got %b exp 00", rsp_valid); end
    step();
    idle_all();
    mid();
    checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL rd_rsp got %b exp 01", rsp_valid); end
    checks++; if (rsp_data !== 8'hA5) begin errors++; $display("FAIL rd_data got %h exp a5", rsp_data); end
    checks++; if (ram_ce !== 1'b0) begin errors++; $display("FAIL rd_idle_ce got %b exp 0", ram_ce); end
    step();
  endtask

  // Write by requester 1 then read of the same address by requester 0.
  task automatic test_back_to_back();
    set_req(1, 1'b1, 1'b1, 1'b0, 10'h040, 8'h77);
    mid();
    checks++; if (req_gnt !== 2'b10) begin errors++; $display("FAIL b2b_wgnt got %b exp 10", req_gnt); end
    step();
    set_req(1, 1'b0, 1'b0, 1'b0, 10'h040, 8'h00);
    set_req(0, 1'b1, 1'b0, 1'b0, 10'h040, 8'h00);
    mid();
    checks++; if (req_gnt !== 2'b01) begin errors++; $display("FAIL b2b_rgnt got %b exp 01", req_gnt); end
    step();
    idle_all();
    mid();
    checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL b2b_rsp got %b exp 01", rsp_valid); end
    checks++; if (rsp_data !== 8'h77) begin errors++; $display("FAIL b2b_data got %h exp 77", rsp_data); end
    step();
  endtask

  task automatic test_alternate();
    logic [1:0] exp_g, exp_r;
    logic [7:0] exp_d;
    do_reset();
    set_req(0, 1'b1, 1'b1, 1'b0, 10'h020, 8'h11);
    step();
    set_req(0, 1'b0, 1'b0, 1'b0, 10'h020, 8'h00);
    set_req(1, 1'b1, 1'b1, 1'b0, 10'h030, 8'h22);
    step();
    do_reset();
    set_req(0, 1'b1, 1'b0, 1'b0, 10'h020, 8'h00);
    set_req(1, 1'b1, 1'b0, 1'b0, 10'h030, 8'h00);
    for (int k = 0; k < 6; k++) begin
      mid();
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      checks++; if (req_gnt !== exp_g) begin errors++; $display("FAIL alt_gnt[%0d] got %b exp %b", k, req_gnt, exp_g); end
      if (k > 0) begin
        exp_r = (k % 2 == 0) ? 2'b10 : 2'b01;
        exp_d = (exp_r == 2'b01) ? 8'h11 : 8'h22;
        checks++; if (rsp_valid !== exp_r) begin errors++; $display("FAIL alt_rsp[%0d] got %b exp %b", k, rsp_valid, exp_r); end
        checks++; if (rsp_data !== exp_d) begin errors++; $display("FAIL alt_data[%0d] got %h exp %h", k, rsp_data, exp_d); end
      end
      step();
    end
    idle_all();
    mid();
    checks++; if (rsp_valid !== 2'b10) begin errors++; $display("FAIL alt_last_rsp got %b exp 10", rsp_valid); end
    checks++; if (rsp_data !== 8'h22) begin errors++; $display("FAIL alt_last_data got %h exp 22", rsp_data); end
    step();
  endtask

  // Requester 1 locks against a competing requester 0: 01, then 16x10, 01, 16x10, ...
  task automatic test_lock();
    logic [1:0] exp_g;
    do_reset();
    set_req(0, 1'b1, 1'b0, 1'b0, 10'h020, 8'h00);
    set_req(1, 1'b1, 1'b0, 1'b1, 10'h030, 8'h00);
    for (int k = 0; k < 40; k++) begin
      mid();
      if (k == 0) exp_g = 2'b01;
      else exp_g = (((k - 1) % 17) < 16) ? 2'b10 : 2'b01;
      checks++; if (req_gnt !== exp_g) begin errors++; $display("FAIL lock_gnt[%0d] got %b exp %b", k, req_gnt, exp_g); end
      step();
    end
    idle_all();
    step();
  endtask

  task automatic test_solo_lock();
    do_reset();
    set_req(0, 1'b1, 1'b0, 1'b1, 10'h020, 8'h00);
    for (int k = 0; k < 20; k++) begin
      mid();
      checks++; if (req_gnt !== 2'b01) begin errors++; $display("FAIL solo_gnt[%0d] got %b exp 01", k, req_gnt); end
      if (k > 0) begin
        checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL solo_rsp[%0d] got %b exp 01", k, rsp_valid); end
      end
      step();
    end
    idle_all();
    step();
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_req(0, 1'b1, 1'b0, 1'b0, 10'h020, 8'h00);
    mid();
    checks++; if (req_gnt !== 2'b01) begin errors++; $display("FAIL rm_pre_gnt got %b exp 01", req_gnt); end
    step();
    reset = 1'b1;
    set_req(1, 1'b1, 1'b0, 1'b0, 10'h030, 8'h00);
    mid();
    checks++; if (req_gnt !== 2'b00) begin errors++; $display("FAIL rm_rst_gnt got %b exp 00", req_gnt); end
    checks++; if (ram_ce !== 1'b0) begin errors++; $display("FAIL rm_rst_ce got %b exp 0", ram_ce); end
    step();
    reset = 1'b0;
    mid();
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL rm_post_rsp got %b exp 00", rsp_valid); end
    checks++; if (req_gnt !== 2'b01) begin errors++; $display("FAIL rm_tie_gnt got %b exp 01", req_gnt); end
    step();
    idle_all();
    step();
  endtask

  task automatic test_idle_hold();
    do_reset();
    set_req(1, 1'b1, 1'b1, 1'b0, 10'h3FF, 8'h5A);
    mid();
    checks++; if (req_gnt !== 2'b10) begin errors++; $display("FAIL idle_gnt got %b exp 10", req_gnt); end
    checks++; if (ram_ad !== 10'h3FF) begin errors++; $display("FAIL idle_wad got %h exp 3ff", ram_ad); end
    step();
    idle_all();
    for (int k = 0; k < 3; k++) begin
      mid();
      checks++; if (ram_ce !== 1'b0) begin errors++; $display("FAIL idle_ce[%0d] got %b exp 0", k, ram_ce); end
      checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL idle_we[%0d] got %b exp 0", k, ram_we); end
      checks++; if (ram_ad !== 10'h3FF) begin errors++; $display("FAIL idle_ad[%0d] got %h exp 3ff", k, ram_ad); end
      checks++; if (ram_din !== 8'h5A) begin errors++; $display("FAIL idle_din[%0d] got %h exp 5a", k, ram_din); end
      checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL idle_rsp[%0d] got %b exp 00", k, rsp_valid); end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_alternate();
    test_lock();
    test_solo_lock();
    test_reset_mid();
    test_idle_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dpb_port_arbiter.md
Name: dpb_port_arbiter

Overview:
- Shares one port (A or B) of the 1024x8 Gowin_DPB feature-map buffer between NREQ requesters, e.g. the image loader, conv-layer reader and result writer of the BCNN pipeline.
- Arbitration is round-robin, with an optional bounded burst lock per requester.
- Drives the RAM port pins directly and returns read data, tagged to the requester that issued the read, one cycle after grant.
- One instance per DPB port. The top level instantiates one per port it needs to share.

Parameters:
- NREQ, 2, number of requesters (2..4).
- AW, 10, RAM address width.
- DW, 8, RAM data width.
- LOCK_MAX, 16, maximum consecutive grants one requester may hold under lock (1..255).

Ports:
- clk  in  1  clock for the arbiter and the RAM port.
- reset  in  1  reset; synchronous, active-high.
- req_valid  in  NREQ  per-requester access request.
- req_we  in  NREQ  1 = write, 0 = read.
- req_lock  in  NREQ  request to keep the grant on the next cycle (burst).
- req_addr  in  NREQ*AW  packed addresses; requester i occupies bits [i*AW +: AW].
- req_wdata  in  NREQ*DW  packed write data; requester i occupies bits [i*DW +: DW].
- req_gnt  out  NREQ  one-hot, combinational; the access is consumed in this cycle.
- rsp_valid  out  NREQ  one-hot; read data valid for requester i.
- rsp_data  out  DW  read data, shared by all requesters, qualified by rsp_valid.
- ram_ce  out  1  to DPB cea/ceb.
- ram_oce  out  1  to DPB ocea/oceb; tied 1 (bypass read mode).
- ram_reset  out  1  to DPB reseta/resetb; equals reset.
- ram_we  out  1  to DPB wrea/wreb.
- ram_ad  out  AW  to DPB ada/adb.
- ram_din  out  DW  to DPB dina/dinb.
- ram_dout  in  DW  from DPB douta/doutb.

Behaviour:
- At most one access per cycle.
- Grant selection:
  - Candidate set is all i with req_valid[i]=1.
  - If there is no lock, search starts at (last_gnt+1) mod NREQ and the first candidate in cyclic order wins.
  - Reset value of last_gnt is NREQ-1, so requester 0 has top priority after reset.
- Lock:
  - Lock applies when the previous cycle's grantee g had req_lock[g]=1, req_valid[g] is still 1, and lock_cnt < LOCK_MAX.
  - While lock applies, g wins regardless of round-robin order.
  - lock_cnt counts consecutive grants to the same requester under lock. It resets to 1 on any grant that is not a lock continuation, and to 0 when idle.
  - When lock_cnt reaches LOCK_MAX, the next cycle reverts to round-robin from g. If no other requester is valid, g may be granted again and lock_cnt restarts at 1.
- last_gnt updates on every grant and holds when idle.
- RAM drive, combinational from the winner w:
  - ram_ce=1, ram_we=req_we[w], ram_ad=addr[w], ram_din=wdata[w].
  - With no winner: ram_ce=0, ram_we=0, and ram_ad/ram_din are held at their last values to avoid toggling.
- Read return:
  - A read granted in cycle T sets a registered one-hot pend_rd.
  - rsp_valid = pend_rd in cycle T+1, and rsp_data = ram_dout in the same cycle.
  - Write grants produce no rsp_valid.
  - Back-to-back reads give one rsp_valid per cycle, in grant order.
- Requester contract: hold req_valid, addr, wdata and we stable until req_gnt. A requester may drop req_valid without a grant.
- Reset values:
  - Reset is synchronous. req_gnt=0, rsp_valid=0, ram_ce=0, ram_we=0, ram_ad=0, ram_din=0, lock_cnt=0, last_gnt=NREQ-1.
  - ram_reset=1 during reset.
- Reset during operation:
  - A read granted in the cycle reset is asserted is dropped; no rsp_valid follows.
  - The arbiter issues no grants while reset=1.
- Simultaneous events:
  - A lock holder competing with new requests keeps the grant until lock ends or LOCK_MAX is reached.
  - Read/write to the same address in consecutive cycles is served in grant order. A read after a write returns the new data.
- Address range: no address wrap or check; the full AW range is legal.

Decomposition:
- Package dpb_arb_pkg holds the AW/DW defaults, LOCK_MAX default, and the function rr_pick(valid, last) returning a one-hot mask.
- One sub-module: dpb_rr_pick, a combinational round-robin priority picker of NREQ bits.
- The lock counter, pend_rd and RAM muxing stay in the top module.

Test Plan:
- Reset, then requester 0 writes 0xA5 to address 0x012. In the same cycle ram_ce=1, ram_we=1, ram_ad=0x012 and ram_din=0xA5. Requester 0 then reads 0x012: rsp_valid=01 one cycle later and rsp_data=0xA5.
- NREQ=2, both reading continuously with lock=0: grants alternate 01, 10, 01, 10. rsp_valid follows the same pattern delayed by one cycle.
- Requester 1 holds lock=1 and valid=1 for 40 cycles while requester 0 is also valid, LOCK_MAX=16: requester 1 gets 16 grants, then requester 0 gets 1, then requester 1 gets 16 again.
- Only requester 0 is valid with lock=1: it is granted every cycle with no bubble at the LOCK_MAX boundary.
- A read is granted at cycle T and reset is asserted at T: no rsp_valid at T+1. After release, requester 0 wins a 2-way tie.
- Idle cycles between accesses: ram_ce=0 and ram_ad holds its last value (0x3FF after an access to 0x3FF). No rsp_valid is generated.
